// File: rtl/bp_resolve_queue.sv
// In-order queue of outstanding branch predictions; checks the oldest one against the
// execute-stage outcome, drives the predictor update stream and the fetch redirect.
module bp_resolve_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     push_i,
  input  logic [PC_W-1:0]          push_pc_i,
  input  logic                     push_taken_i,
  input  logic [PC_W-1:0]          push_target_i,
  output logic                     full_o,
  input  logic                     resolve_i,
  input  logic                     resolve_taken_i,
  input  logic [PC_W-1:0]          resolve_target_i,
  output logic                     update_en_o,
  output logic [PC_W-1:0]          update_pc_o,
  output logic                     update_taken_o,
  output logic                     mispredict_o,
  output logic [PC_W-1:0]          redirect_pc_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               update_en_q, update_en_d;
  logic [PC_W-1:0]    update_pc_q, update_pc_d;
  logic               update_taken_q, update_taken_d;
  logic               mispredict_q, mispredict_d;
  logic [PC_W-1:0]    redirect_pc_q, redirect_pc_d;

  logic [PC_W-1:0]    pc_mem     [DEPTH];
  logic               taken_mem  [DEPTH];
  logic [PC_W-1:0]    target_mem [DEPTH];

  logic               full_c, empty_c;
  logic               push_acc_c, res_acc_c, wr_en_c, mis_c;
  logic [PC_W-1:0]    head_pc_c, head_target_c, redirect_c;
  logic               head_taken_c;

  assign full_c     = (count_q == CNT_W'(DEPTH)) | (state_q == ST_FLUSH);
  assign empty_c    = (count_q == '0);
  assign push_acc_c = en_i & push_i & ~full_c;
  assign res_acc_c  = en_i & resolve_i & ~empty_c;

  assign head_pc_c     = pc_mem[rd_ptr_q];
  assign head_taken_c  = taken_mem[rd_ptr_q];
  assign head_target_c = target_mem[rd_ptr_q];

  assign mis_c = (head_taken_c != resolve_taken_i) |
                 (head_taken_c & resolve_taken_i & (head_target_c != resolve_target_i));
  assign redirect_c = resolve_taken_i ? resolve_target_i : head_pc_c + PC_W'(4);

  // A mispredicted resolve discards every younger entry, including a same-cycle push.
  assign wr_en_c = push_acc_c & ~(res_acc_c & mis_c);

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    update_en_d    = 1'b0;
    update_pc_d    = update_pc_q;
    update_taken_d = update_taken_q;
    mispredict_d   = 1'b0;
    redirect_pc_d  = redirect_pc_q;

    case (state_q)
      ST_RUN: begin
        if (res_acc_c) begin
          update_en_d    = 1'b1;
          update_pc_d    = head_pc_c;
          update_taken_d = resolve_taken_i;
          mispredict_d   = mis_c;
          redirect_pc_d  = redirect_c;
          if (mis_c) begin
            state_d  = ST_FLUSH;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push_acc_c) begin
              wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end else if (push_acc_c) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
          count_d  = count_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (en_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_RUN;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      update_en_q    <= 1'b0;
      update_pc_q    <= '0;
      update_taken_q <= 1'b0;
      mispredict_q   <= 1'b0;
      redirect_pc_q  <= '0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      update_en_q    <= update_en_d;
      update_pc_q    <= update_pc_d;
      update_taken_q <= update_taken_d;
      mispredict_q   <= mispredict_d;
      redirect_pc_q  <= redirect_pc_d;
    end
  end

  // Entry payload needs no reset: count_q alone decides which slots are valid.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_c) begin
      pc_mem[wr_ptr_q]     <= push_pc_i;
      taken_mem[wr_ptr_q]  <= push_taken_i;
      target_mem[wr_ptr_q] <= push_target_i;
    end
  end

  assign full_o         = full_c;
  assign empty_o        = empty_c;
  assign count_o        = count_q;
  assign update_en_o    = update_en_q;
  assign update_pc_o    = update_pc_q;
  assign update_taken_o = update_taken_q;
  assign mispredict_o   = mispredict_q;
  assign redirect_pc_o  = redirect_pc_q;

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed, table-driven bench for bp_resolve_queue plus hand-written FLUSH sequences.
module tb_bp_resolve_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PC_W  = 32;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            en_i = 1'b0;
  logic            push_i = 1'b0;
  logic [PC_W-1:0] push_pc_i = '0;
  logic            push_taken_i = 1'b0;
  logic [PC_W-1:0] push_target_i = '0;
  logic            full_o;
  logic            resolve_i = 1'b0;
  logic            resolve_taken_i = 1'b0;
  logic [PC_W-1:0] resolve_target_i = '0;
  logic            update_en_o;
  logic [PC_W-1:0] update_pc_o;
  logic            update_taken_o;
  logic            mispredict_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic            empty_o;
  logic [2:0]      count_o;

  always #5 clk_i = ~clk_i;

  bp_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .en_i             (en_i),
    .push_i           (push_i),
    .push_pc_i        (push_pc_i),
    .push_taken_i     (push_taken_i),
    .push_target_i    (push_target_i),
    .full_o           (full_o),
    .resolve_i        (resolve_i),
    .resolve_taken_i  (resolve_taken_i),
    .resolve_target_i (resolve_target_i),
    .update_en_o      (update_en_o),
    .update_pc_o      (update_pc_o),
    .update_taken_o   (update_taken_o),
    .mispredict_o     (mispredict_o),
    .redirect_pc_o    (redirect_pc_o),
    .empty_o          (empty_o),
    .count_o          (count_o)
  );

  typedef struct {
    logic        rst, en, push;
    logic [31:0] ppc;
    logic        ptk;
    logic [31:0] ptgt;
    logic        res, rtk;
    logic [31:0] rtgt;
    logic        ue;
    logic [31:0] upc;
    logic        ut, mis;
    logic [31:0] rpc;
    logic        emp, full;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(logic rst, logic en, logic push, logic [31:0] ppc, logic ptk,
                              logic [31:0] ptgt, logic res, logic rtk, logic [31:0] rtgt,
                              logic ue, logic [31:0] upc, logic ut, logic mis,
                              logic [31:0] rpc, logic emp, logic full, logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.en = en; v.push = push; v.ppc = ppc; v.ptk = ptk; v.ptgt = ptgt;
    v.res = res; v.rtk = rtk; v.rtgt = rtgt;
    v.ue = ue; v.upc = upc; v.ut = ut; v.mis = mis; v.rpc = rpc;
    v.emp = emp; v.full = full; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [step %0d]: got 0x%08h expected 0x%08h", nm, idx, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, then sample just after the active edge.
  task automatic drive(input logic rst, input logic en, input logic push, input logic [31:0] ppc,
                       input logic ptk, input logic [31:0] ptgt, input logic res,
                       input logic rtk, input logic [31:0] rtgt);
    rst_i = rst; en_i = en; push_i = push; push_pc_i = ppc; push_taken_i = ptk;
    push_target_i = ptgt; resolve_i = res; resolve_taken_i = rtk; resolve_target_i = rtgt;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // rst en push ppc ptk ptgt res rtk rtgt | ue upc ut mis rpc emp full cnt
    vq.push_back(mk(1,1,0,32'h0,0,32'h0,0,0,32'h0,        0,32'h0,0,0,32'h0,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'h100,1,32'h200,0,0,32'h0,    0,32'h0,0,0,32'h0,0,0,3'd1));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,1,32'h200,      1,32'h100,1,0,32'h200,1,0,3'd0));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        0,32'h100,1,0,32'h200,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'h10,0,32'h0,0,0,32'h0,       0,32'h100,1,0,32'h200,0,0,3'd1));
    vq.push_back(mk(0,1,1,32'h20,0,32'h0,0,0,32'h0,       0,32'h100,1,0,32'h200,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'h30,0,32'h0,0,0,32'h0,       0,32'h100,1,0,32'h200,0,0,3'd3));
    vq.push_back(mk(0,1,1,32'h40,0,32'h0,0,0,32'h0,       0,32'h100,1,0,32'h200,0,1,3'd4));
    vq.push_back(mk(0,1,1,32'h50,0,32'h0,0,0,32'h0,       0,32'h100,1,0,32'h200,0,1,3'd4));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h10,0,0,32'h14,0,0,3'd3));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h20,0,0,32'h24,0,0,3'd2));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h30,0,0,32'h34,0,0,3'd1));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h40,0,0,32'h44,1,0,3'd0));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        0,32'h40,0,0,32'h44,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'h300,0,32'h0,0,0,32'h0,      0,32'h40,0,0,32'h44,0,0,3'd1));
    vq.push_back(mk(0,1,1,32'h304,1,32'h500,0,0,32'h0,    0,32'h40,0,0,32'h44,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'h308,0,32'h0,0,0,32'h0,      0,32'h40,0,0,32'h44,0,0,3'd3));
    vq.push_back(mk(0,1,1,32'h30C,0,32'h0,1,1,32'h380,    1,32'h300,1,1,32'h380,1,1,3'd0));
    vq.push_back(mk(0,1,1,32'h400,0,32'h0,0,0,32'h0,      0,32'h300,1,0,32'h380,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'hFFFFFFFC,1,32'h0,0,0,32'h0, 0,32'h300,1,0,32'h380,0,0,3'd1));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h1234,     1,32'hFFFFFFFC,0,1,32'h0,1,1,3'd0));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,0,0,32'h0,        0,32'hFFFFFFFC,0,0,32'h0,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'h10,0,32'h0,0,0,32'h0,       0,32'hFFFFFFFC,0,0,32'h0,0,0,3'd1));
    vq.push_back(mk(0,1,1,32'h20,0,32'h0,0,0,32'h0,       0,32'hFFFFFFFC,0,0,32'h0,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'h30,0,32'h0,0,0,32'h0,       0,32'hFFFFFFFC,0,0,32'h0,0,0,3'd3));
    vq.push_back(mk(0,1,1,32'h40,0,32'h0,0,0,32'h0,       0,32'hFFFFFFFC,0,0,32'h0,0,1,3'd4));
    vq.push_back(mk(0,1,1,32'h50,0,32'h0,1,0,32'h0,       1,32'h10,0,0,32'h14,0,0,3'd3));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h20,0,0,32'h24,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'h60,0,32'h0,1,0,32'h0,       1,32'h30,0,0,32'h34,0,0,3'd2));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h40,0,0,32'h44,0,0,3'd1));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h60,0,0,32'h64,1,0,3'd0));
    vq.push_back(mk(0,1,1,32'h70,0,32'h0,0,0,32'h0,       0,32'h60,0,0,32'h64,0,0,3'd1));
    vq.push_back(mk(0,1,1,32'h80,0,32'h0,0,0,32'h0,       0,32'h60,0,0,32'h64,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'h90,0,32'h0,0,0,32'h0,       0,32'h60,0,0,32'h64,0,0,3'd3));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        1,32'h70,0,0,32'h74,0,0,3'd2));
    vq.push_back(mk(0,1,1,32'hA0,0,32'h0,0,0,32'h0,       0,32'h70,0,0,32'h74,0,0,3'd3));
    vq.push_back(mk(0,0,1,32'hB0,0,32'h0,1,0,32'h0,       0,32'h70,0,0,32'h74,0,0,3'd3));
    vq.push_back(mk(1,1,1,32'hC0,0,32'h0,1,0,32'h0,       0,32'h0,0,0,32'h0,1,0,3'd0));
    vq.push_back(mk(0,1,0,32'h0,0,32'h0,1,0,32'h0,        0,32'h0,0,0,32'h0,1,0,3'd0));

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      drive(v.rst, v.en, v.push, v.ppc, v.ptk, v.ptgt, v.res, v.rtk, v.rtgt);
      chk("update_en",    i, 32'(update_en_o),    32'(v.ue));
      chk("update_pc",    i, update_pc_o,         v.upc);
      chk("update_taken", i, 32'(update_taken_o), 32'(v.ut));
      chk("mispredict",   i, 32'(mispredict_o),   32'(v.mis));
      chk("redirect_pc",  i, redirect_pc_o,       v.rpc);
      chk("empty",        i, 32'(empty_o),        32'(v.emp));
      chk("full",         i, 32'(full_o),         32'(v.full));
      chk("count",        i, 32'(count_o),        32'(v.cnt));
    end

    // FLUSH holds while en_i is low, and the mispredict pulse still clears.
    drive(0, 1, 1, 32'h200, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_flush_count_push", 100, 32'(count_o), 32'd1);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1, 1, 32'h240);
    chk("seq_flush_mis",        101, 32'(mispredict_o), 32'd1);
    chk("seq_flush_redirect",   101, redirect_pc_o, 32'h240);
    chk("seq_flush_full",       101, 32'(full_o), 32'd1);
    drive(0, 0, 1, 32'h210, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_hold_mis_clear",   102, 32'(mispredict_o), 32'd0);
    chk("seq_hold_ue_clear",    102, 32'(update_en_o), 32'd0);
    chk("seq_hold_full",        102, 32'(full_o), 32'd1);
    drive(0, 0, 1, 32'h210, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_hold_full2",       103, 32'(full_o), 32'd1);
    chk("seq_hold_count",       103, 32'(count_o), 32'd0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_run_full",         104, 32'(full_o), 32'd0);
    drive(0, 1, 1, 32'h220, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_run_push",         105, 32'(count_o), 32'd1);

    // Reset during FLUSH returns straight to RUN with nothing pending.
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1, 1, 32'h260);
    chk("seq_rst_pre_mis",      106, 32'(mispredict_o), 32'd1);
    drive(1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    chk("seq_rst_full",         107, 32'(full_o), 32'd0);
    chk("seq_rst_redirect",     107, redirect_pc_o, 32'h0);
    chk("seq_rst_empty",        107, 32'(empty_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
